rr_share_arbiter: RTL and testbench
===================================

# rr_share_arbiter

Round-robin arbiter that shares one resource (bus port, datapath slot) among N requesters with a request/grant/release handshake. It replaces the free-running rotating selector with a demand-driven one: only requesting agents are granted, ownership is held until release, a watchdog revokes over-long holds, and one turnaround cycle separates consecutive owners. It sits between requester agents and the resource mux, and `gnt_id` drives the mux select directly.

## Interface
- `N`, 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, 15: maximum consecutive cycles one owner may hold the grant; 0 disables the watchdog.
- `IDW`, $clog2(N): width of `gnt_id` (derived; not overridden).
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: request per agent; level, held until granted and for the whole ownership.
- `release` input 1: current owner ends ownership; sampled only while `gnt_valid`=1.
- `gnt` output N: one-hot grant, registered; all zero when no owner.
- `gnt_id` output IDW: index of current owner; holds the last owner while idle.
- `gnt_valid` output 1: high while any grant is active (equal to OR of `gnt`).
- `timeout` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, BUSY, GAP. Reset values: state=IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, priority pointer `last`=N-1, hold counter=0.
- Arbitration, evaluated in IDLE and GAP: scan `req` starting at index (`last`+1) mod N and wrapping upward; the first set bit wins. The winner is registered into `gnt`/`gnt_id`, `last` takes the winner index, the hold counter loads 1, and the FSM enters BUSY. If no request is pending, GAP goes to IDLE and IDLE stays in IDLE.
- BUSY exits to GAP, clearing `gnt` and `gnt_valid` on that edge, on any of the following:
  - `release`=1;
  - `req[gnt_id]`=0 (owner withdrew);
  - `MAX_HOLD`≠0 and counter==`MAX_HOLD` with neither of the above (watchdog). In this case `timeout`=1 for the first GAP cycle only.
- Otherwise BUSY holds and the counter increments. The counter saturates and never wraps; its width is $clog2(MAX_HOLD+1), minimum 1.
- Priority precedence when several exit causes coincide: release/withdraw take precedence over watchdog, so `timeout` stays 0.
- GAP lasts exactly one cycle with `gnt`=0 (bus turnaround). Arbitration in GAP uses the updated `last`, so the previous owner has lowest priority. It is re-granted only if it is the sole requester.
- Requests from non-owners during BUSY are ignored; they are not latched. An agent that drops `req` before being granted loses nothing, since there is no queue.
- `release` while `gnt_valid`=0 is ignored.
- `rst` asserted in any state forces the reset values on the next edge, regardless of `req` and `release`. The first grant after reset goes to the lowest-indexed requester.

## Timing
- Request-to-grant latency from IDLE: `req` seen high at edge k means `gnt` is high after edge k (visible in cycle k+1).
- Release-to-next-grant: `release` sampled at edge k means `gnt`=0 in cycle k+1 (GAP) and the new `gnt` is visible in cycle k+2. Throughput is one handover per 2 cycles minimum.
- Maximum ownership is `MAX_HOLD` cycles of `gnt` high. `timeout` is asserted in the same cycle that `gnt` first reads 0.
- All outputs come straight from flops; there are no combinational paths from `req` or `release` to outputs.
- Fairness: with all N requesting continuously, each agent is granted exactly once per N ownerships.

## Test plan
- Reset/first grant (N=4): deassert `rst` with `req`=4'b1010. Required: `gnt`=4'b0010 and `gnt_id`=1 one cycle later; all outputs are 0 during reset.
- Rotation: `req`=4'b1111 held, owner pulses `release` one cycle after each grant. Required: grant order 0,1,2,3,0 with one `gnt`=0 cycle between each, and new grants every 2 cycles.
- Watchdog (MAX_HOLD=4): `req`=4'b0100 held, no release. Required: `gnt`=4'b0100 for exactly 4 cycles, then a GAP with `timeout`=1 for one cycle, then agent 2 is re-granted. Then set `req`=4'b0101. Required: after the next timeout, agent 0 is granted.
- Coincident exits: `release`=1 on the cycle the counter equals `MAX_HOLD`. Required: `timeout` stays 0 and the handover is normal.
- Withdraw: owner 3 drops `req[3]` mid-hold while `req[0]`=1. Required: `gnt`=0 on the next cycle, then `gnt`=4'b0001.
- Reset mid-BUSY: assert `rst` while `gnt`=4'b1000. Required: all outputs 0 on the next edge, and after reset `req`=4'b1001 grants agent 0.

Source files
------------

// File: rtl/rr_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_share_arbiter : demand-driven round-robin owner arbiter with hold watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_share_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  // `release` is a reserved word, so the owner's release strobe is release_gnt
  input  logic           release_gnt,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last;
  logic [CW-1:0]  hold_cnt;

  logic           found;
  logic [IDW-1:0] win;
  logic [N-1:0]   win_onehot;
  logic           owner_drop;
  logic           wd_expire;

  // Scan upward from the slot after the previous owner, wrapping at N.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    win_onehot = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        win             = IDW'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

  assign owner_drop = release_gnt || !req[gnt_id];
  assign wd_expire  = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last      <= IDW'(N - 1);
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (owner_drop || wd_expire) begin
            state     <= ST_GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            // Voluntary exits win over the watchdog, so no timeout then.
            timeout   <= !owner_drop;
          end else if (hold_cnt != {CW{1'b1}}) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          timeout <= 1'b0;
          if (found) begin
            state     <= ST_BUSY;
            gnt       <= win_onehot;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            last      <= win;
            hold_cnt  <= CW'(1);
          end else begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_share_arbiter : directed + random bench against an ownership model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rr_share_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int n_tests  = 0;
  int n_failed = 0;

  // Reference: who owns the resource, for how long, and who owned it last.
  int m_owner;
  int m_id;
  int m_last;
  int m_hold;
  bit m_to;

  rr_share_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .release_gnt(rel),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (after + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    int w;
    if (rst) begin
      m_owner = -1; m_id = 0; m_last = N - 1; m_hold = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      if (rel || !req[m_owner]) begin
        m_owner = -1; m_to = 1'b0;
      end else if (m_hold == MAX_HOLD) begin
        m_owner = -1; m_to = 1'b1;
      end else begin
        m_hold++;
      end
    end else begin
      m_to = 1'b0;
      w = pick(req, m_last);
      if (w >= 0) begin
        m_owner = w; m_id = w; m_last = w; m_hold = 1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] q, input logic l);
    logic [N-1:0] eg;
    rst = r; req = q; rel = l;
    model_step();
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), 32'(m_id));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset(input logic [N-1:0] q);
    for (int i = 0; i < 3; i++) drive(1'b1, q, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rq;
    int to_seen;

    // Reset, then first grant goes to the lowest requester of 1010.
    do_reset(4'b1010);
    check("rst_gnt", 32'(gnt), 32'h0);
    drive(1'b0, 4'b1010, 1'b0);
    check("first_gnt", 32'(gnt), 32'b0010);
    check("first_id", 32'(gnt_id), 32'd1);

    // Rotation with release one cycle after each grant.
    do_reset(4'b0000);
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b1111, m_owner >= 0);
    check("rot_last_id", 32'(gnt_id), 32'd0);

    // Watchdog with a lone requester, then a second requester joins.
    do_reset(4'b0000);
    to_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'b0100, 1'b0);
      if (timeout) to_seen++;
    end
    check("wd_pulses", 32'(to_seen), 32'd2);
    while (m_to == 1'b0) drive(1'b0, 4'b0101, 1'b0);
    drive(1'b0, 4'b0101, 1'b0);
    check("wd_handover", 32'(gnt), 32'b0001);

    // Release coinciding with watchdog expiry.
    do_reset(4'b0000);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 4'b0011, (m_owner >= 0) && (m_hold == MAX_HOLD));

    // Owner 3 withdraws mid-hold while agent 0 waits.
    do_reset(4'b0000);
    drive(1'b0, 4'b1000, 1'b0);
    drive(1'b0, 4'b1001, 1'b0);
    drive(1'b0, 4'b0001, 1'b0);
    check("wd_gap", 32'(gnt), 32'h0);
    drive(1'b0, 4'b0001, 1'b0);
    check("wd_next", 32'(gnt), 32'b0001);

    // Reset while owner 3 holds.
    do_reset(4'b0000);
    drive(1'b0, 4'b1000, 1'b0);
    check("mid_busy", 32'(gnt), 32'b1000);
    drive(1'b1, 4'b1000, 1'b0);
    check("mid_rst", 32'({gnt, gnt_valid, timeout}), 32'h0);
    drive(1'b0, 4'b1001, 1'b0);
    check("post_rst", 32'(gnt), 32'b0001);

    // Random traffic with occasional releases and resets.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      rq = rq ^ (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
      drive($urandom_range(0, 199) == 0, rq, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
`default_nettype wire
